// File: rtl/centering_datapath.sv
// rtl/centering_datapath.sv - block mean removal: buffer N samples, compute mean, emit saturated centered samples
module centering_datapath #(
  parameter int DW = 16,
  parameter int N  = 128
) (
  input  logic                 CLK_cdp,
  input  logic                 RST_cdp,
  input  logic                 En_SUM,
  input  logic                 En_DIV,
  input  logic                 En_SUB,
  input  logic signed [DW-1:0] DIN,
  output logic signed [DW-1:0] DOUT,
  output logic                 DOUT_Valid,
  output logic signed [DW-1:0] MEAN,
  output logic                 CDP_Done,
  output logic                 ERR
);

  localparam int LW = $clog2(N);
  localparam int AW = DW + LW;

  typedef enum logic [2:0] {IDLE, ACC, FULL, MEANOK, SUB, DONE} state_t;

  state_t               state, state_nxt;
  logic [LW-1:0]        wr_ptr, rd_ptr, wr_addr;
  logic signed [AW-1:0] acc;
  logic signed [DW-1:0] sbuf [N];
  logic signed [DW-1:0] rd_data, sat_val;
  logic signed [DW:0]   diff;
  logic                 multi, proto_err, do_first, do_store, do_div, do_sub;
  logic                 last_wr, last_rd;

  assign last_wr = (wr_ptr == LW'(N-1));
  assign last_rd = (rd_ptr == LW'(N-1));
  assign multi   = (En_SUM & En_DIV) | (En_SUM & En_SUB) | (En_DIV & En_SUB);

  always_comb begin
    state_nxt = state;
    proto_err = 1'b0;
    do_first  = 1'b0;
    do_store  = 1'b0;
    do_div    = 1'b0;
    do_sub    = 1'b0;
    if (multi) begin
      proto_err = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (En_SUM) begin
            do_first  = 1'b1;
            state_nxt = ACC;
          end
          proto_err = En_DIV | En_SUB;
        end
        ACC: begin
          if (En_SUM) begin
            do_store = 1'b1;
            if (last_wr) state_nxt = FULL;
          end
          proto_err = En_DIV | En_SUB;
        end
        FULL: begin
          if (En_DIV) begin
            do_div    = 1'b1;
            state_nxt = MEANOK;
          end
          proto_err = En_SUM | En_SUB;
        end
        MEANOK, SUB: begin
          if (En_SUB) begin
            do_sub    = 1'b1;
            state_nxt = last_rd ? DONE : SUB;
          end
          proto_err = En_SUM | En_DIV;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Difference carries one guard bit so overflow shows up as a sign mismatch
  always_comb begin
    wr_addr = do_first ? '0 : wr_ptr;
    rd_data = sbuf[rd_ptr];
    diff    = (DW+1)'(rd_data) - (DW+1)'(MEAN);
    if (diff[DW] != diff[DW-1])
      sat_val = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_val = diff[DW-1:0];
  end

  always_ff @(posedge CLK_cdp) begin
    if (!RST_cdp && (do_first || do_store))
      sbuf[wr_addr] <= DIN;
  end

  always_ff @(posedge CLK_cdp) begin
    if (RST_cdp) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge CLK_cdp) begin
    if (RST_cdp) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      acc        <= '0;
      DOUT       <= '0;
      DOUT_Valid <= 1'b0;
      MEAN       <= '0;
      CDP_Done   <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      DOUT_Valid <= 1'b0;
      if (proto_err) ERR <= 1'b1;
      if (do_first) begin
        acc      <= AW'(DIN);
        wr_ptr   <= LW'(1);
        rd_ptr   <= '0;
        CDP_Done <= 1'b0;
      end
      if (do_store) begin
        acc    <= acc + AW'(DIN);
        wr_ptr <= wr_ptr + LW'(1);
      end
      // Arithmetic shift by log2(N) is exactly this slice of the accumulator
      if (do_div) MEAN <= acc[LW +: DW];
      if (do_sub) begin
        DOUT       <= sat_val;
        DOUT_Valid <= 1'b1;
        rd_ptr     <= rd_ptr + LW'(1);
        if (last_rd) CDP_Done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_centering_datapath.sv
// tb/tb_centering_datapath.sv - directed self-checking bench for centering_datapath
module tb_centering_datapath;

  localparam int NS = 128;

  logic               clk = 1'b0;
  logic               rst, en_sum, en_div, en_sub;
  logic signed [15:0] din, dout, mean;
  logic               dout_valid, done, err;

  int s [NS];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  centering_datapath #(.DW(16), .N(NS)) dut (
    .CLK_cdp(clk), .RST_cdp(rst), .En_SUM(en_sum), .En_DIV(en_div), .En_SUB(en_sub),
    .DIN(din), .DOUT(dout), .DOUT_Valid(dout_valid), .MEAN(mean),
    .CDP_Done(done), .ERR(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expv(input int i, input int m);
    int d;
    d = s[i] - m;
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en_sum = 1'b1;
      din    = 16'(s[i]);
      step();
      if (i == 0) chk("done_clr_at_start", int'(done), 0);
    end
    en_sum = 1'b0;
  endtask

  task automatic sub_range(input int lo, input int hi, input int m);
    for (int i = lo; i <= hi; i++) begin
      en_sub = 1'b1;
      step();
      chk("dout_valid", int'(dout_valid), 1);
      chk("dout", int'(dout), expv(i, m));
      chk("done_with_last", int'(done), (i == NS-1) ? 1 : 0);
    end
    en_sub = 1'b0;
  endtask

  task automatic finish_block(input int m);
    en_div = 1'b1;
    step();
    en_div = 1'b0;
    chk("mean", int'(mean), m);
    chk("no_valid_after_div", int'(dout_valid), 0);
    sub_range(0, NS-1, m);
    step();
    chk("valid_drops", int'(dout_valid), 0);
    chk("done_held", int'(done), 1);
    chk("dout_holds", int'(dout), expv(NS-1, m));
  endtask

  initial begin
    rst = 1'b1; en_sum = 1'b0; en_div = 1'b0; en_sub = 1'b0; din = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_mean", int'(mean), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    // constant block: mean 100, all outputs zero
    for (int i = 0; i < NS; i++) s[i] = 100;
    feed(0, NS-1);
    finish_block(100);

    // ramp 0..127: sum 8128, mean 63, outputs -63..64; starts straight from DONE
    for (int i = 0; i < NS; i++) s[i] = i;
    feed(0, NS-1);
    finish_block(63);

    // alternating -1,0: sum -64, floor mean -1, outputs 0,1
    for (int i = 0; i < NS; i++) s[i] = (i % 2 == 0) ? -1 : 0;
    feed(0, NS-1);
    finish_block(-1);

    // 127 x -32768 then 32767: sum -4128769, floor(/128) = -32257
    // outputs -511 for the first 127, last 65024 saturates to 32767
    for (int i = 0; i < NS; i++) s[i] = (i == NS-1) ? 32767 : -32768;
    feed(0, NS-1);
    finish_block(-32257);
    chk("err_clean_after_legal", int'(err), 0);

    // En_DIV mid-accumulate: flagged, ignored, block still completes
    do_reset();
    for (int i = 0; i < NS; i++) s[i] = i;
    feed(0, 63);
    chk("err_before_bad_div", int'(err), 0);
    en_div = 1'b1;
    step();
    en_div = 1'b0;
    chk("err_bad_div", int'(err), 1);
    chk("mean_bad_div", int'(mean), 0);
    feed(64, NS-1);
    finish_block(63);
    chk("err_sticky", int'(err), 1);

    // En_SUM with En_SUB: flagged, sample not stored, pointer not advanced
    // 3i-100: sum 11584, mean floor(90.5) = 90
    do_reset();
    for (int i = 0; i < NS; i++) s[i] = 3*i - 100;
    feed(0, 31);
    en_sum = 1'b1; en_sub = 1'b1; din = 16'sd999;
    step();
    en_sum = 1'b0; en_sub = 1'b0;
    chk("err_multi", int'(err), 1);
    chk("valid_multi", int'(dout_valid), 0);
    feed(32, NS-1);
    finish_block(90);

    // reset on the 50th En_SUB aborts the block
    do_reset();
    chk("err_cleared_by_rst", int'(err), 0);
    feed(0, NS-1);
    en_div = 1'b1;
    step();
    en_div = 1'b0;
    chk("mean_pre_abort", int'(mean), 90);
    sub_range(0, 48, 90);
    en_sub = 1'b1; rst = 1'b1;
    step();
    en_sub = 1'b0; rst = 1'b0;
    chk("abort_dout", int'(dout), 0);
    chk("abort_valid", int'(dout_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_mean", int'(mean), 0);
    en_sub = 1'b1;
    step();
    en_sub = 1'b0;
    chk("abort_sub_in_idle_err", int'(err), 1);
    chk("abort_sub_in_idle_valid", int'(dout_valid), 0);

    // new block after abort: 5i-300, sum 2240, mean floor(17.5) = 17
    for (int i = 0; i < NS; i++) s[i] = 5*i - 300;
    feed(0, NS-1);
    finish_block(17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
